// File: rtl/line_uart_sender_pkg.sv
`default_nettype none
// ============================================================================
// line_uart_sender_pkg : UART framing constants, FSM encoding, baud helper
// Rev 1.0
// ============================================================================
package line_uart_sender_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKIP  = 3'd1,
        S_FETCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// uart_byte_tx : one 8N1 frame per start strobe; owns baud counter and bit order
// Rev 1.0
// ============================================================================
module uart_byte_tx
    import line_uart_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       uart_tx_o
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             w_last;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        tx_done_o = 1'b0;
        tx_d      = 1'b1;
        w_last    = (cnt_q == CNT_LAST);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    data_d  = byte_i;
                end
            end
            S_START: begin
                if (w_last) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    cnt_d  = '0;
                    data_d = {1'b0, data_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        tx_done_o = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Pin level is registered from the next state so it changes on the bit boundary.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = data_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_busy_o = (state_q != S_IDLE);
    assign uart_tx_o = tx_q;

endmodule
`default_nettype wire

// File: rtl/line_uart_sender.sv
`default_nettype none
// ============================================================================
// line_uart_sender : sends a NUL-terminated packed ASCII line as 8N1 bytes
// Rev 1.0
// ============================================================================
module line_uart_sender
    import line_uart_sender_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int LINE_BYTES = 82
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*LINE_BYTES-1:0] line_i,
    input  logic                    send_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    uart_tx_o
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               LINE_W       = 8 * LINE_BYTES;
    localparam int               IDX_W        = $clog2(LINE_BYTES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LINE_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_END      = IDX_W'(LINE_BYTES);

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        w_top;
    logic              w_tx_start;
    logic              w_tx_busy;
    logic              w_tx_done;

    assign w_top = line_q[LINE_W-1 -: 8];

    // The controller parks in S_START for the whole frame; the byte
    // transmitter does the actual start/data/stop sequencing.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        idx_d      = idx_q;
        w_tx_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_i) begin
                    line_d  = line_i;
                    idx_d   = '0;
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                if (w_top != 8'h00) begin
                    state_d = S_FETCH;
                end else if (idx_q < IDX_LAST) begin
                    line_d = {line_q[LINE_W-9:0], 8'h00};
                    idx_d  = idx_q + 1'b1;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FETCH: begin
                if (idx_q == IDX_END || w_top == 8'h00) begin
                    state_d = S_FIN;
                end else if (!w_tx_busy) begin
                    w_tx_start = 1'b1;
                    line_d     = {line_q[LINE_W-9:0], 8'h00};
                    idx_d      = idx_q + 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (w_tx_done) begin
                    state_d = S_FETCH;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done_o = (state_q == S_FIN);

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_i    (w_top),
        .start_i   (w_tx_start),
        .tx_busy_o (w_tx_busy),
        .tx_done_o (w_tx_done),
        .uart_tx_o (uart_tx_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_line_uart_sender.sv
`default_nettype none
// ============================================================================
// tb_line_uart_sender : directed + random lines against a line/UART frame model
// Rev 1.0
// ============================================================================
module tb_line_uart_sender;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 92_000;
    localparam int LB       = 82;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int LW       = 8 * LB;
    localparam int FRAME    = 10 * CPB;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [LW-1:0] line_i = '0;
    logic          send_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          uart_tx_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int frame_err   = 0;
    int send_cyc    = 0;

    byte unsigned rx_q[$];
    byte unsigned exp_q[$];
    int           start_q[$];

    line_uart_sender #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .LINE_BYTES (LB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .send_i    (send_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .uart_tx_o (uart_tx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_o === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Line receiver: every bit must hold one level for exactly CPB cycles.
    initial begin : monitor
        logic [9:0] bits;
        bit         ok;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx_o === 1'b0) begin
                start_q.push_back(cyc);
                ok      = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int s = 0; s < FRAME; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s % CPB == 0) bits[s/CPB] = uart_tx_o;
                    else if (uart_tx_o !== bits[s/CPB]) ok = 1'b0;
                end
                if (!aborted) begin
                    if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
                    else rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: drop leading NULs, then every byte up to a NUL or the end.
    task automatic build_expect(input logic [LW-1:0] l);
        int i;
        exp_q.delete();
        i = 0;
        while (i < LB && l[LW-1-8*i -: 8] == 8'h00) i++;
        while (i < LB && l[LW-1-8*i -: 8] != 8'h00) begin
            exp_q.push_back(l[LW-1-8*i -: 8]);
            i++;
        end
    endtask

    task automatic make_random(output logic [LW-1:0] l, input int min_n);
        int k, n, p;
        l = '0;
        k = $urandom_range(LB - 9, 0);
        n = $urandom_range(8, min_n);
        p = k;
        for (int i = 0; i < n && p < LB; i++) begin
            l[LW-1-8*p -: 8] = ($urandom_range(3, 0) == 0) ? 8'h0A : 8'($urandom_range(255, 1));
            p++;
        end
        if (p < LB) p++;
        for (int i = 0; i < 3 && p < LB; i++) begin
            l[LW-1-8*p -: 8] = 8'($urandom_range(255, 1));
            p++;
        end
    endtask

    task automatic start_line(input logic [LW-1:0] l);
        @(posedge clk);
        #1;
        line_i = l;
        send_i = 1'b1;
        rx_q.delete();
        start_q.delete();
        build_expect(l);
        @(posedge clk);
        #1;
        send_i   = 1'b0;
        send_cyc = cyc;
        for (int k = 0; k < LB; k++) line_i[8*k +: 8] = 8'($urandom);
    endtask

    task automatic wait_done(output int done_at);
        int n, budget, busy_bad;
        bit seen;
        n        = 0;
        seen     = 1'b0;
        busy_bad = 0;
        done_at  = 0;
        budget   = exp_q.size() * (FRAME + 1) + LB + 20;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done_o === 1'b1) begin
                seen    = 1'b1;
                done_at = cyc;
                if (busy_o !== 1'b0) busy_bad++;
            end else if (busy_o !== 1'b1) begin
                busy_bad++;
            end
        end
        check_bit("done_seen", seen, 1'b1);
        check_int("busy_profile", busy_bad, 0);
    endtask

    task automatic wait_first_start();
        int n = 0;
        while (start_q.size() == 0 && n < LB + 10) begin
            @(negedge clk);
            n++;
        end
        check_bit("first_start_seen", start_q.size() > 0, 1'b1);
    endtask

    task automatic finish_check(input string tag, input int done_at);
        int n;
        n = exp_q.size();
        check_int({tag, "_frames"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check_int($sformatf("%s_byte%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
        check_int({tag, "_starts"}, start_q.size(), n);
        check_int({tag, "_frame_err"}, frame_err, 0);
        check_bit({tag, "_done_min"}, (done_at - send_cyc) >= n * FRAME, 1'b1);
        check_bit({tag, "_done_max"}, (done_at - send_cyc) <= n * FRAME + LB + 6, 1'b1);
        if (start_q.size() > 0)
            check_bit({tag, "_first_lat"}, (start_q[0] - send_cyc) <= LB + 2, 1'b1);
        for (int i = 1; i < start_q.size(); i++)
            check_int($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], FRAME + 1);
    endtask

    initial begin
        logic [LW-1:0] l;
        int            done_at;

        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_tx", uart_tx_o, 1'b1);
        check_bit("rst_busy", busy_o, 1'b0);
        check_bit("rst_done", done_o, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("idle_tx", uart_tx_o, 1'b1);
        check_bit("idle_busy", busy_o, 1'b0);

        // "Hi\n" right-aligned with its terminator
        l = '0;
        l[31:0] = 32'h4869_0A00;
        start_line(l);
        wait_done(done_at);
        finish_check("hi", done_at);
        repeat (5) @(posedge clk);
        #1;
        check_int("hi_done_once", done_cnt, 1);

        // Empty line; a send raised during the done cycle must be dropped
        start_line('0);
        wait_done(done_at);
        finish_check("zero", done_at);
        check_bit("zero_done_84", (done_at - send_cyc) <= 84, 1'b1);
        line_i = {LB{8'h41}};
        send_i = 1'b1;
        @(posedge clk);
        #1;
        send_i = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check_bit("fin_send_busy", busy_o, 1'b0);
        check_int("fin_send_starts", start_q.size(), 0);
        check_int("zero_done_cnt", done_cnt, 2);

        // "AB" with a 5-cycle send held mid-frame
        l = '0;
        l[23:0] = 24'h4142_00;
        start_line(l);
        wait_first_start();
        repeat (3 * CPB) @(posedge clk);
        #1;
        line_i = {LB{8'h5A}};
        send_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_i = 1'b0;
        wait_done(done_at);
        finish_check("ab", done_at);
        repeat (FRAME + 20) @(posedge clk);
        #1;
        check_int("ab_no_extra", start_q.size(), 2);
        check_int("ab_done_cnt", done_cnt, 3);

        // Reset during the data bits of the first byte
        l = '0;
        l[31:0] = 32'h4869_0A00;
        start_line(l);
        wait_first_start();
        repeat (2 * CPB + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("arst_tx", uart_tx_o, 1'b1);
        check_bit("arst_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check_int("arst_starts", start_q.size(), 1);
        check_int("arst_rx", rx_q.size(), 0);
        check_bit("arst_idle_busy", busy_o, 1'b0);
        check_int("arst_done_cnt", done_cnt, 3);

        // Full-capacity line without terminator, then a send the cycle after done
        start_line({LB{8'h55}});
        wait_done(done_at);
        finish_check("full", done_at);
        make_random(l, 1);
        start_line(l);
        wait_done(done_at);
        finish_check("after_done", done_at);
        repeat (3) @(posedge clk);
        #1;
        check_int("full_done_cnt", done_cnt, 5);

        for (int t = 0; t < 8; t++) begin
            make_random(l, 0);
            start_line(l);
            wait_done(done_at);
            finish_check($sformatf("rnd%0d", t), done_at);
            repeat (3) @(posedge clk);
        end
        #1;
        check_int("final_done_cnt", done_cnt, 13);
        check_bit("final_tx", uart_tx_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_uart_sender.md
Name: line_uart_sender

Overview:
- Stage directly downstream of the key/line-request logic in top.
- Accepts a wide packed ASCII line plus a one-cycle send strobe.
- Serialises the line as bytes onto an 8N1 UART TX pin, stopping at the NUL terminator.
- Reports busy and a completion pulse, so the upstream can gate further requests.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, UART bit rate
LINE_BYTES, 82, line capacity in bytes; line width = 8*LINE_BYTES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
line  input  8*LINE_BYTES  packed ASCII, string-literal layout (first char in highest non-zero byte)
send  input  1  one-cycle request strobe; line sampled on the same edge
busy  output  1  high from the accepted send until done
done  output  1  one-cycle pulse after the last stop bit (or an empty line)
uart_tx  output  1  serial out, idle high

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: uart_tx=1, busy=0, done=0. All counters are 0 and the FSM is in IDLE.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously). No partial byte resumes afterwards.
- CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (434 at the defaults). Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, SKIP, FETCH, START, DATA, STOP, FIN.
- IDLE:
  - send=1 latches line into an internal shift register, sets busy=1 on the next cycle, and goes to SKIP.
  - send=0 holds the state.
- SKIP:
  - Examines the top byte of the shift register, one byte per cycle.
  - If the byte is 0x00 and the byte index < LINE_BYTES-1: shift left 8 bits, increment the index, stay in SKIP. This discards leading padding.
  - If the byte is non-zero: go to FETCH.
  - If all bytes are zero (index reaches LINE_BYTES-1 with a zero byte): go to FIN with no UART activity.
- FETCH:
  - Copies the top byte into the TX data register, shifts the line left 8 bits, increments the index, and goes to START.
  - If the top byte is 0x00 (terminator), goes to FIN instead.
  - If the index has reached LINE_BYTES (all bytes consumed), goes to FIN instead.
- START: uart_tx=0 for one bit time, then go to DATA.
- DATA: 8 bits, LSB first, one bit time each, then go to STOP.
- STOP: uart_tx=1 for one bit time, then go back to FETCH. No idle gap between bytes beyond the single FETCH cycle.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then go to IDLE.
- Latency: the first start-bit edge comes at most LINE_BYTES+2 cycles after the accepted send.
- A send while busy=1 is ignored; it is not queued.
- A send in the same cycle as a done pulse is ignored. It is accepted from the cycle after FIN.
- line may change freely after the accepting edge; only the latched copy is transmitted.
- A bare 0x0A inside the line is transmitted like any other byte. Only 0x00 terminates.

Decomposition:
- Shared package holds:
  - the UART framing constants (DATA_BITS=8, STOP_BITS=1);
  - the FSM state encoding;
  - the function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- One sub-module: uart_byte_tx.
  - Inputs: byte, start strobe.
  - Outputs: tx_busy, tx_done pulse, uart_tx.
  - Owns the baud counter and the START/DATA/STOP bit sequencing.
- line_uart_sender keeps the line shift register, SKIP/FETCH/FIN control and the busy/done outputs.

Test Plan:
- Reset, then "Hi\n\0" right-aligned in line, one send pulse -> uart_tx emits bytes 0x48, 0x69, 0x0A, each 10 bits of 434 cycles. done pulses once, 3*4340 + ≤LINE_BYTES+6 cycles after send. busy is high throughout.
- All-zero line, send -> uart_tx stays 1, done pulses within 84 cycles, busy high only until then.
- Second send held 5 cycles mid-frame of "AB\0" -> output is exactly 0x41, 0x42 once. Exactly one done pulse.
- rst_n asserted during the DATA bits of the first byte -> uart_tx=1 and busy=0 immediately. After release, no further edges until a new send.
- Line of 82 non-zero bytes 0x55 with no terminator -> exactly 82 frames transmitted, then done. Verifies termination on capacity.
- send asserted in the cycle after done -> new transmission starts. The first start-bit edge of the new frame comes ≤84 cycles later.
